// File: rtl/uart_pkg.sv
// Shared UART constants and types for the receive path.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH    = 8;
  localparam int unsigned UART_RX_FIFO_DEPTH = 16;

  typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/rx_strobe_edge.sv
// Rising-edge detector for a strobe that may arrive as a pulse or a held level.
module rx_strobe_edge (
  input  logic clk,
  input  logic nRst,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      in_q <= 1'b0;
    end else begin
      in_q <= in;
    end
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures data_ready rising edges into a FWFT circular buffer.
// Optional UART_RX_FIFO_DROP_CNT_EN adds a saturating dropped-byte counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter  int unsigned DEPTH      = UART_RX_FIFO_DEPTH,
  localparam int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_ready,
  input  logic                  rd_en,
  input  logic                  clear_overrun,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic [ADDR_W:0]       count,
  output logic                  overrun
`ifdef UART_RX_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic                  push_ev;
  logic                  pop_ok;
  logic                  wr_ok;
  logic                  drop;

  rx_strobe_edge u_ready_edge (
    .clk  (clk),
    .nRst (nRst),
    .in   (data_ready),
    .rise (push_ev)
  );

  // A push into a full FIFO still lands when a pop frees the head slot in the same cycle.
  always_comb begin
    full     = (count == FULL_CNT);
    rd_valid = (count != '0);
    pop_ok   = enable && rd_en && rd_valid;
    wr_ok    = enable && push_ev && (!full || pop_ok);
    drop     = enable && push_ev && full && !pop_ok;
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!enable) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (clear_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      drop_count <= '0;
    end else if (drop) begin
      if (clear_overrun) begin
        drop_count <= 8'd1;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end else if (clear_overrun) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: expected bytes queued on push, compared on pop.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = int'(UART_RX_FIFO_DEPTH);

  logic       clk;
  logic       nRst;
  logic       enable;
  logic [7:0] data_in;
  logic       data_ready;
  logic       rd_en;
  logic       clear_overrun;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [4:0] count;
  logic       overrun;
`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [7:0] drop_count;
  int         exp_drop;
`endif

  int         total;
  int         bad;
  logic [7:0] sb [$];
  logic       exp_ovr;
  logic       dr_prev;

  uart_rx_fifo dut (
    .clk           (clk),
    .nRst          (nRst),
    .enable        (enable),
    .data_in       (data_in),
    .data_ready    (data_ready),
    .rd_en         (rd_en),
    .clear_overrun (clear_overrun),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .full          (full),
    .count         (count),
    .overrun       (overrun)
`ifdef UART_RX_FIFO_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus with the reference model advanced alongside it.
  task automatic cyc(input logic dr, input logic [7:0] d, input logic re, input logic clr);
    logic pop_ok;
    logic push_ev;
    logic drop;
    data_ready    = dr;
    data_in       = d;
    rd_en         = re;
    clear_overrun = clr;
    push_ev = dr && !dr_prev;
    dr_prev = dr;
    drop    = 1'b0;
    pop_ok  = enable && re && (sb.size() != 0);
    if (pop_ok) check("rd_data", 32'(rd_data), 32'(sb[0]));
    if (!enable) begin
      sb.delete();
    end else begin
      if (pop_ok) void'(sb.pop_front());
      if (push_ev) begin
        if (sb.size() < DEPTH) sb.push_back(d);
        else drop = 1'b1;
      end
    end
    if (drop) exp_ovr = 1'b1;
    else if (clr) exp_ovr = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    if (drop) exp_drop = clr ? 1 : ((exp_drop < 255) ? exp_drop + 1 : 255);
    else if (clr) exp_drop = 0;
`endif
    step();
    rd_en         = 1'b0;
    clear_overrun = 1'b0;
    check("count", 32'(count), 32'(sb.size()));
    check("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
    check("full", 32'(full), 32'(sb.size() == DEPTH));
    check("overrun", 32'(overrun), 32'(exp_ovr));
`ifdef UART_RX_FIFO_DROP_CNT_EN
    check("drop_count", 32'(drop_count), 32'(exp_drop));
`endif
  endtask

  task automatic push_pulse(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (sb.size() == 0) break;
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drained_rd_data", 32'(rd_data), 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_ovr = 1'b0;
    dr_prev = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    exp_drop = 0;
`endif
    nRst = 1'b0;
    enable = 1'b1;
    data_in = 8'h00;
    data_ready = 1'b0;
    rd_en = 1'b0;
    clear_overrun = 1'b0;

    #12;
    check("rst_count", 32'(count), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_full", 32'(full), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    step();
    nRst = 1'b1;

    // Basic ordering
    push_pulse(8'h41);
    push_pulse(8'h42);
    push_pulse(8'h43);
    check("three_count", 32'(count), 32'd3);
    drain();

    // Held level gives a single push
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("level_count", 32'(count), 32'd1);
    drain();

    // Overflow drops the 17th byte, then clear
    for (int i = 1; i <= 17; i++) push_pulse(8'(i));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_overrun", 32'(overrun), 32'd1);
    drain();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overrun), 32'd0);

    // Simultaneous push/pop when full, then when empty
    for (int i = 0; i < DEPTH; i++) push_pulse(8'(8'h60 + i));
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("full_pp_count", 32'(count), 32'd16);
    check("full_pp_overrun", 32'(overrun), 32'd0);
    drain();
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("empty_pp_count", 32'(count), 32'd1);
    drain();

    // Interleaved traffic across pointer wrap
    for (int c = 0; c < 80; c++) begin
      cyc(c % 2 == 0, 8'($urandom_range(0, 255)), c % 2 == 1, 1'b0);
    end
    drain();

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) push_pulse(8'(8'hB0 + i));
    #3;
    nRst = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'h0);
    check("arst_rd_valid", 32'(rd_valid), 32'h0);
    nRst = 1'b1;
    sb.delete();
    exp_ovr = 1'b0;
    dr_prev = 1'b0;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    exp_drop = 0;
`endif

    // Flush keeps overrun; a level held across re-enable makes no push
    for (int i = 0; i < 17; i++) push_pulse(8'(8'hC0 + i));
    enable = 1'b0;
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    check("flush_count", 32'(count), 32'h0);
    check("flush_overrun", 32'(overrun), 32'd1);
    enable = 1'b1;
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    check("reenable_count", 32'(count), 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    push_pulse(8'h12);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each completed byte announced by the receiver's data_ready strobe and queues it in a circular buffer.
- Presents the oldest byte to the consumer (CPU bus / display logic) via a first-word-fall-through pop handshake.
- Decouples bursty serial reception from a consumer that reads at its own pace; reports overrun when bytes arrive into a full buffer.

Parameters:
- DATA_WIDTH, 8, width of each queued byte; matches receiver data_out.
- DEPTH, 16, number of entries; must be a power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- nRst  input  1  asynchronous active-low reset.
- enable  input  1  block enable; low flushes the FIFO.
- data_in  input  DATA_WIDTH  byte from receiver data_out.
- data_ready  input  1  receiver byte-complete strobe; may be a pulse or a level held for several cycles.
- rd_en  input  1  consumer pop request.
- clear_overrun  input  1  clears the sticky overrun flag.
- rd_data  output  DATA_WIDTH  head entry, valid while rd_valid=1.
- rd_valid  output  1  FIFO non-empty.
- full  output  1  count == DEPTH.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (nRst=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overrun=0, edge register=0. Outputs: rd_valid=0, full=0, rd_data=0. Storage contents are not reset.
- Push event: rising edge of data_ready, i.e. data_ready=1 and the registered previous data_ready=0. A level held N cycles yields exactly one push. Push samples data_in in that same cycle.
- Pop event: rd_en=1 and count>0. rd_en while empty is ignored, with no error.
- FWFT: rd_data is combinationally mem[rd_ptr] while count>0, and 0 while empty.
- Latency: a byte pushed at edge k is visible on rd_data/rd_valid after edge k.
- Push when count<DEPTH: mem[wr_ptr]<=data_in; wr_ptr increments and wraps modulo DEPTH.
- Push when full and no pop: byte dropped, overrun<=1, pointers unchanged.
- Simultaneous push and pop, full: both succeed; count stays DEPTH; no overrun.
- Simultaneous push and pop, empty: push succeeds, pop ignored; count becomes 1.
- Simultaneous push and pop, otherwise: both succeed; count unchanged.
- clear_overrun=1: overrun<=0. If an overrun occurs in the same cycle, set wins and overrun=1.
- enable=0 (synchronous flush): pointers and count go to 0; pushes and pops are ignored; overrun is held; the edge register still tracks data_ready, so a level held across re-enable does not create a push.
- Derived outputs: full=(count==DEPTH), rd_valid=(count!=0). Both are decoded from registered count; no combinational path from data_ready or rd_en to these outputs.
- Pointer arithmetic: ADDR_W bits with natural wrap; count uses ADDR_W+1 bits.

Optional Feature:
- Macro: UART_RX_FIFO_DROP_CNT_EN.
- Defined: adds output drop_count, 8 bits, reset 0. It increments on every dropped byte, saturates at 255, and clears with clear_overrun (set wins in the same cycle, leaving drop_count=1 after clear with simultaneous drop).
- Undefined: port and counter absent; only the sticky overrun flag is reported.

Decomposition:
- uart_pkg: UART_DATA_WIDTH=8, UART_RX_FIFO_DEPTH=16, typedef uart_byte_t (logic [7:0]).
- Sub-module rx_strobe_edge: registers the strobe and outputs a one-cycle rise pulse. Clock clk, reset nRst, input in, output rise. Reusable for other strobe inputs.
- Storage array, pointers, and count live in uart_rx_fifo.

Test Plan:
- After reset, push 0x41, 0x42, 0x43 as one-cycle data_ready pulses; pop three times -> rd_data 0x41, 0x42, 0x43 in order; count 3→0; rd_valid drops after the third pop.
- data_ready held high for 5 cycles with data_in=0x55 -> count=1, a single entry 0x55.
- Push 17 distinct bytes into DEPTH=16 -> full=1, count=16, overrun=1; reads return bytes 1..16 and the 17th is absent. Then clear_overrun -> overrun=0.
- Fill to 16, then push 0x99 with rd_en=1 in the same cycle -> count stays 16, overrun=0, 0x99 is the last entry read. Repeat at empty -> count=1.
- Push 40 bytes while popping one every other cycle (pointer wrap) -> output sequence matches input exactly, no loss.
- Push 4 bytes, assert nRst=0 mid-clock for 1 ns -> count=0 and rd_valid=0 immediately. Separately, pulse enable=0 for one cycle -> count=0 with overrun unchanged.
